// File: rtl/cla32.sv
// cla32: 32-bit two-level carry-lookahead adder, {o_c, o_sum} = a + b + cin.
// Latency: none; purely combinational from {a, b, cin} to {o_sum, o_c}.
// Backpressure: none; CLK/RSTb exist only for uniform integration and never touch the result.

// ---------------------------------------------------------------------------
// cla32_la4: generic 4-wide lookahead cell.
// Given four (generate, propagate) pairs and a carry-in, it produces the carry
// into each of the four positions plus the combined (G, P) of the block.
// The same equations serve bit-level groups and group-level lookahead.
// ---------------------------------------------------------------------------
module cla32_la4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [3:0] c_o,
  output logic       gg_o,
  output logic       gp_o
);

  // Flattened lookahead carries: every carry is a two-level AND-OR of c_i,
  // so nothing ripples from one position to the next.
  always_comb begin
    c_o[0] = c_i;
    c_o[1] = g_i[0]
           | (p_i[0] & c_i);
    c_o[2] = g_i[1]
           | (p_i[1] & g_i[0])
           | (p_i[1] & p_i[0] & c_i);
    c_o[3] = g_i[2]
           | (p_i[2] & g_i[1])
           | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c_i);
  end

  // Block generate/propagate, independent of the carry-in so the next
  // lookahead level can consume them in parallel.
  always_comb begin
    gg_o = g_i[3]
         | (p_i[3] & g_i[2])
         | (p_i[3] & p_i[2] & g_i[1])
         | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    gp_o = p_i[3] & p_i[2] & p_i[1] & p_i[0];
  end

endmodule

// ---------------------------------------------------------------------------
// cla32_grp4: level-1 4-bit CLA group.
// Forms bit generate/propagate, derives internal carries through the
// lookahead cell, and exports the group (G, P) for level 2.
// ---------------------------------------------------------------------------
module cla32_grp4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       gg_o,
  output logic       gp_o
);

  logic [3:0] bit_g;
  logic [3:0] bit_p;
  logic [3:0] bit_c;

  // Bit-level generate and propagate; propagate uses XOR so it doubles as
  // the half-sum for the final sum bit.
  always_comb begin
    bit_g = a_i & b_i;
    bit_p = a_i ^ b_i;
  end

  cla32_la4 u_la (
    .g_i  (bit_g),
    .p_i  (bit_p),
    .c_i  (c_i),
    .c_o  (bit_c),
    .gg_o (gg_o),
    .gp_o (gp_o)
  );

  // Sum bit is the half-sum XORed with the lookahead carry into that bit.
  always_comb begin
    sum_o = bit_p ^ bit_c;
  end

endmodule

// ---------------------------------------------------------------------------
// cla32: top level.
// Eight 4-bit groups; two 4-group lookahead units (bits 15:0 and 31:16) and a
// flattened top combine that produces c16 and c32 straight from cin, so the
// upper half never waits on a carry rippled through the lower half.
// ---------------------------------------------------------------------------
module cla32 (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] o_sum,
  output logic        o_c
);

  // Clock and reset are integration-only ports; reduced into a sink so the
  // arithmetic path stays free of any dependence on them.
  logic unused_clk_rst;
  assign unused_clk_rst = CLK ^ RSTb;

  logic [7:0] grp_g;
  logic [7:0] grp_p;
  logic [7:0] grp_c;     // carry into group k, i.e. c[4k]
  logic       lo_g;
  logic       lo_p;
  logic       hi_g;
  logic       hi_p;
  logic       c16;
  logic       c32;

  // Level 1: eight independent 4-bit CLA groups.
  for (genvar k = 0; k < 8; k++) begin : g_grp
    cla32_grp4 u_grp (
      .a_i   (a[4*k +: 4]),
      .b_i   (b[4*k +: 4]),
      .c_i   (grp_c[k]),
      .sum_o (o_sum[4*k +: 4]),
      .gg_o  (grp_g[k]),
      .gp_o  (grp_p[k])
    );
  end

  // Level 2, lower half: carries into groups 0..3 (c0, c4, c8, c12) from cin.
  cla32_la4 u_lcu_lo (
    .g_i  (grp_g[3:0]),
    .p_i  (grp_p[3:0]),
    .c_i  (cin),
    .c_o  (grp_c[3:0]),
    .gg_o (lo_g),
    .gp_o (lo_p)
  );

  // Level 2, upper half: carries into groups 4..7 (c16, c20, c24, c28) from c16.
  cla32_la4 u_lcu_hi (
    .g_i  (grp_g[7:4]),
    .p_i  (grp_p[7:4]),
    .c_i  (c16),
    .c_o  (grp_c[7:4]),
    .gg_o (hi_g),
    .gp_o (hi_p)
  );

  // Top combine: c16 and c32 are both expressed directly in terms of cin and
  // the half-block (G, P) pairs, keeping the critical path at one lookahead
  // step per level.
  always_comb begin
    c16 = lo_g | (lo_p & cin);
    c32 = hi_g
        | (hi_p & lo_g)
        | (hi_p & lo_p & cin);
  end

  // Carry-out of bit 31 is bit 32 of the full sum.
  always_comb begin
    o_c = c32;
  end

endmodule

// File: tb/tb_cla32.sv
// tb_cla32: randomized + directed check of cla32 against a 33-bit arithmetic model.
// Latency: driver applies inputs 1 ns after each rising edge; monitor samples 2 ns later.
// Backpressure: none; expected results are queued by the driver and popped by the monitor.
module tb_cla32;

  logic        clk;
  logic        rstb;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] o_sum;
  logic        o_c;

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;
  bit          drv_done;

  cla32 dut (
    .CLK   (clk),
    .RSTb  (rstb),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .o_sum (o_sum),
    .o_c   (o_c)
  );

  // 20 ns clock period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Apply one vector just after a rising edge and queue the reference result.
  task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic vr, input string nm);
    logic [32:0] ref_sum;
    @(posedge clk);
    #1;
    a    = va;
    b    = vb;
    cin  = vc;
    rstb = vr;
    ref_sum = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
    exp_q.push_back(ref_sum);
    name_q.push_back(nm);
  endtask

  // Directed expected values checked as plain constants too.
  task automatic apply_const(input logic [31:0] va, input logic [31:0] vb,
                             input logic vc, input logic vr,
                             input logic [32:0] want, input string nm);
    @(posedge clk);
    #1;
    a    = va;
    b    = vb;
    cin  = vc;
    rstb = vr;
    exp_q.push_back(want);
    name_q.push_back(nm);
  endtask

  // Monitor: 2 ns after the inputs changed, pop one expectation and compare.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        logic [32:0] want;
        string       nm;
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        total++;
        if ({o_c, o_sum} !== want) begin
          bad++;
          $display("FAIL %s: a=%h b=%h cin=%b got c=%b sum=%h want c=%b sum=%h",
                   nm, a, b, cin, o_c, o_sum, want[32], want[31:0]);
        end
      end
    end
  end

  // Stimulus: directed corner cases, then randomized vectors with RSTb toggling.
  initial begin
    total    = 0;
    bad      = 0;
    drv_done = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    rstb     = 1'b1;

    apply_const(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 33'h0_0000_0000, "zero_rst");
    apply_const(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 33'h0_0000_0000, "zero");
    apply_const(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000, "prop_chain");
    apply_const(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, "all_gen");
    apply_const(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0001_0000, "bit16_cross");
    apply_const(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, "to_msb");
    apply_const(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 33'h0_ACF1_3569, "mixed");
    apply_const(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, "msb_wrap");
    apply_const(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 33'h1_0000_0000, "prop_chain_rst");
    apply_const(32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_1000, "grp_cross");

    // Each group boundary: carry entering group k from all-ones below it.
    for (int k = 1; k < 8; k++) begin
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF >> (32 - 4 * k);
      apply(ones, 32'h0, 1'b1, 1'b0, "grp_boundary");
    end

    for (int i = 0; i < 110; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = $urandom();
      // Bias some vectors toward long propagate runs.
      if (i % 5 == 0) rb = ~ra;
      apply(ra, rb, 1'(i % 2), 1'($urandom_range(0, 3) == 0), "random");
    end

    drv_done = 1'b1;
    // Drain: bounded wait for the monitor to consume everything.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
